// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  // MULHSU signs only rs1; MULHU/DIVU/REMU are fully unsigned.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: radix-2 shift-add multiply step (mode 0)
// or restoring divide step (mode 1) on the {acc, lo} register pair.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    // remainder < divisor, so the shifted value needs one extra bit
    rem_sh = {acc, lo[XLEN-1]};
    ge     = rem_sh >= {1'b0, opnd};
    diff   = rem_sh[XLEN-1:0] - opnd;
    if (mode) begin
      acc_nxt = ge ? diff : rem_sh[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ge};
    end else begin
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle sequencer: XLEN-iteration multiply / restoring divide.
// Optional MULDIV_PERF_CNT_EN adds perf_ops / perf_busy counters.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            ex_stall
`ifdef MULDIV_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_busy
`endif
);

  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITR = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, rs1_neg_q, rs1_neg_d;

  logic              fire, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [XLEN-1:0]   acc_nx, lo_nx, quot_fix, rem_fix, fix_res;
  logic [2*XLEN-1:0] prod_fix;

  assign in_ready  = (state_q == IDLE);
  assign ex_stall  = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign fire      = in_ready && in_valid && !flush;

  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .mode    (state_q == DIV),
    .acc     (acc_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nx),
    .lo_nxt  (lo_nx)
  );

  // Accept-cycle operand conditioning and early-out detection
  always_comb begin
    a_neg    = rs1_signed(funct3) && rs1[XLEN-1];
    b_neg    = rs2_signed(funct3) && rs2[XLEN-1];
    abs_a    = a_neg ? -rs1 : rs1;
    abs_b    = b_neg ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1 == SMIN) && (rs2 == '1);
    if (div_zero) spec_res = funct3[1] ? rs1 : '1;
    else          spec_res = funct3[1] ? '0 : SMIN;
  end

  // Sign fix-up applied to the final iteration's outputs
  always_comb begin
    prod_fix = neg_q ? -{acc_nx, lo_nx} : {acc_nx, lo_nx};
    quot_fix = neg_q ? -lo_nx : lo_nx;
    rem_fix  = rs1_neg_q ? -acc_nx : acc_nx;
    case (f3_q)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    rs1_neg_d = rs1_neg_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          f3_d      = funct3;
          neg_d     = a_neg ^ b_neg;
          rs1_neg_d = a_neg;
          cnt_d     = '0;
          acc_d     = '0;
          if (div_zero || div_ovf) begin
            state_d = DONE;
            res_d   = spec_res;
          end else if (funct3[2]) begin
            state_d = DIV;
            lo_d    = abs_a;
            opnd_d  = abs_b;
          end else begin
            state_d = MUL;
            lo_d    = abs_b;
            opnd_d  = abs_a;
          end
        end
      end
      MUL, DIV: begin
        acc_d = acc_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITR) begin
          state_d = DONE;
          res_d   = fix_res;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          res_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      rs1_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      rs1_neg_q <= rs1_neg_d;
    end
  end

`ifdef MULDIV_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
      if (ex_stall)               perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M vectors, flush/reset
// and backpressure scenarios, plus randomized operations against a 64-bit model.
module tb_ex_muldiv_seq;
  import muldiv_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, ex_stall;
  logic [31:0] rs1 = '0, rs2 = '0, result;
  logic [2:0]  funct3 = '0;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] perf_ops, perf_busy;
`endif

  int          checks = 0, errors = 0;
  logic [31:0] exp_arr [256];
  int          wr_idx = 0, rd_idx = 0, n_done = 0;

  ex_muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ex_stall  (ex_stall)
`ifdef MULDIV_PERF_CNT_EN
    ,
    .perf_ops  (perf_ops),
    .perf_busy (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Architectural RV32M result from 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0]        up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    up = {32'b0, a} * {32'b0, b};
    p  = '0;
    r  = '0;
    case (f)
      F3_MUL:    begin p = sa * sb; r = p[31:0];  end
      F3_MULH:   begin p = sa * sb; r = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F3_MULHU:  r = up[63:32];
      F3_DIV:    if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
      F3_DIVU:   r = (b == 0) ? '1 : a / b;
      F3_REM:    if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return SMIN;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at posedge+1, check latency, stall and backpressure behaviour
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int rdy_lat);
    int          lat;
    bit          special;
    logic [31:0] hold;
    special = f[2] && ((b == 0) || (!f[0] && a == SMIN && b == '1));
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    funct3    = f;
    rs1       = a;
    rs2       = b;
    out_ready = (rdy_lat == 0);
    exp_arr[wr_idx % 256] = ref_op(f, a, b);
    wr_idx++;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        funct3   = 3'($urandom);
      end
      if (!out_valid) chk("busy_stall", 32'(ex_stall), 32'd1);
    end while (!out_valid && lat < 3 * XLEN);
    chk("latency", 32'(lat), special ? 32'd1 : 32'(XLEN + 1));
    if (out_valid) begin
      hold = result;
      repeat (rdy_lat) begin
        @(posedge clk); #1;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_result", result, hold);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_done++;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_result", result, 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_stall", 32'(ex_stall), 32'd0);
    end
  endtask

  task automatic dir(input string nm, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv);
    chk(nm, ref_op(f, a, b), expv);
    run_op(f, a, b, 0);
  endtask

  // Compare process: every sampled cycle out of reset
  always @(negedge clk) begin
    if (rst) rd_idx <= wr_idx;
    else begin
      chk("stall_vs_ready", 32'(ex_stall), 32'(!in_ready));
      if (out_valid) begin
        if (rd_idx >= wr_idx) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else begin
          chk("result", result, exp_arr[rd_idx % 256]);
          if (out_ready && !flush) rd_idx <= rd_idx + 1;
        end
      end else chk("idle_result_zero", result, 32'd0);
      if (flush && ex_stall) rd_idx <= wr_idx;
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    dir("MUL_7x-3",      F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    dir("MULH_min2",     F3_MULH,   SMIN,         SMIN,          32'h4000_0000);
    dir("MULHU_ones",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    dir("MULHSU_-1x2",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);
    dir("DIV_-7/2",      F3_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    dir("REM_-7/2",      F3_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    dir("DIVU_100/7",    F3_DIVU,   32'd100,      32'd7,         32'd14);
    dir("REMU_100/7",    F3_REMU,   32'd100,      32'd7,         32'd2);
    dir("DIV_5/0",       F3_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF);
    dir("REM_5/0",       F3_REM,    32'd5,        32'd0,         32'd5);
    dir("DIV_ovf",       F3_DIV,    SMIN,         32'hFFFF_FFFF, SMIN);
    dir("REM_ovf",       F3_REM,    SMIN,         32'hFFFF_FFFF, 32'd0);

    // backpressure in DONE
    run_op(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    // flush during DIV iteration 10
    in_valid = 1'b1; funct3 = F3_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    exp_arr[wr_idx % 256] = ref_op(F3_DIV, 32'd1000, 32'd3);
    wr_idx++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_stall", 32'(ex_stall), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (XLEN + 4) @(posedge clk);
    #1 chk("flush_no_valid", 32'(out_valid), 32'd0);
    dir("MUL_6x7", F3_MUL, 32'd6, 32'd7, 32'd42);

    // flush in IDLE blocks acceptance
    in_valid = 1'b1; flush = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_block", 32'(ex_stall), 32'd0);

    // asynchronous reset mid-MUL
    in_valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd11; rs2 = 32'd13;
    exp_arr[wr_idx % 256] = ref_op(F3_MUL, 32'd11, 32'd13);
    wr_idx++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_stall", 32'(ex_stall), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    n_done = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), int'($urandom_range(0, 3)));

`ifdef MULDIV_PERF_CNT_EN
    chk("perf_ops", perf_ops, 32'(n_done));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
